// File: rtl/sync_hs_pkg.sv
// Shared types for the round-robin 4-phase handshake arbiter: FSM state encoding
// and the default per-phase watchdog limit.
package sync_hs_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'b00,
        REQ     = 2'b01,
        RELEASE = 2'b10
    } state_e;

    localparam int unsigned DefaultTimeoutCycles = 1024;

endpackage

// File: rtl/prim_flop_2sync.sv
// Two-flop synchronizer for bringing asynchronous levels into the clk_i domain.
module prim_flop_2sync #(
    parameter int               Width      = 16,
    parameter logic [Width-1:0] ResetValue = '0
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic [Width-1:0] d_i,
    output logic [Width-1:0] q_o
);

    logic [Width-1:0] stage1_reg;
    logic [Width-1:0] stage2_reg;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            stage1_reg <= ResetValue;
            stage2_reg <= ResetValue;
        end else begin
            stage1_reg <= d_i;
            stage2_reg <= stage1_reg;
        end
    end

    assign q_o = stage2_reg;

endmodule

// File: rtl/sync_hs_arbiter.sv
// Round-robin arbiter sharing one 4-phase req/ack channel between NumReq requesters.
// Define SYNC_HS_TIMEOUT_EN to add a per-phase watchdog that reports aborts on err_o.
module sync_hs_arbiter
    import sync_hs_pkg::*;
#(
    parameter int          NumReq        = 4,
    parameter int          DataWidth     = 32,
    parameter int unsigned TimeoutCycles = DefaultTimeoutCycles
) (
    input  logic                          clk_i,
    input  logic                          rst_i,
    input  logic [NumReq-1:0]             req_valid_i,
    input  logic [NumReq*DataWidth-1:0]   req_data_i,
    output logic [NumReq-1:0]             req_ready_o,
    output logic [NumReq-1:0]             done_o,
    output logic                          err_o,
    output logic                          hs_req_o,
    output logic [DataWidth-1:0]          hs_data_o,
    input  logic                          hs_ack_i,
    output logic                          busy_o,
    output logic [$clog2(NumReq)-1:0]     grant_idx_o
);

    localparam int IdxW = $clog2(NumReq);

    if (NumReq < 2 || TimeoutCycles < 2) begin : g_bad_params
        $error("sync_hs_arbiter: NumReq and TimeoutCycles must both be at least 2");
    end

    state_e                state_reg;
    logic [IdxW-1:0]       ptr_reg;
    logic [IdxW-1:0]       grant_idx_reg;
    logic                  hs_req_reg;
    logic [DataWidth-1:0]  hs_data_reg;
    logic [NumReq-1:0]     done_reg;
    logic                  ack_s;

    logic [IdxW-1:0]       cand;
    logic [IdxW-1:0]       pick_idx;
    logic                  pick_found;
    logic [IdxW-1:0]       ptr_next;
    logic                  grant_en;

    prim_flop_2sync #(
        .Width      (1),
        .ResetValue (1'b0)
    ) u_ack_sync (
        .clk_i  (clk_i),
        .rst_ni (~rst_i),
        .d_i    (hs_ack_i),
        .q_o    (ack_s)
    );

    // First valid requester at or after ptr_reg, wrapping modulo NumReq.
    always_comb begin
        cand       = '0;
        pick_idx   = '0;
        pick_found = 1'b0;
        for (int i = 0; i < NumReq; i++) begin
            cand = IdxW'((int'(ptr_reg) + i) % NumReq);
            if (!pick_found && req_valid_i[cand]) begin
                pick_found = 1'b1;
                pick_idx   = cand;
            end
        end
    end

    assign ptr_next    = (pick_idx == IdxW'(NumReq - 1)) ? '0 : pick_idx + 1'b1;
    // A stale ack (e.g. still high after reset) blocks new grants.
    assign grant_en    = (state_reg == IDLE) && !ack_s && pick_found;
    assign req_ready_o = grant_en ? (NumReq'(1) << pick_idx) : '0;

`ifdef SYNC_HS_TIMEOUT_EN
    localparam int CntW = $clog2(TimeoutCycles);

    logic [CntW-1:0] cnt_reg;
    logic            err_flag_reg;
    logic            err_reg;
    logic            phase_timeout;

    assign phase_timeout = (cnt_reg == CntW'(TimeoutCycles - 1));
    assign err_o         = err_reg;
`else
    assign err_o = 1'b0;
`endif

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_reg     <= IDLE;
            ptr_reg       <= '0;
            grant_idx_reg <= '0;
            hs_req_reg    <= 1'b0;
            hs_data_reg   <= '0;
            done_reg      <= '0;
`ifdef SYNC_HS_TIMEOUT_EN
            cnt_reg       <= '0;
            err_flag_reg  <= 1'b0;
            err_reg       <= 1'b0;
`endif
        end else begin
            done_reg <= '0;
`ifdef SYNC_HS_TIMEOUT_EN
            err_reg  <= 1'b0;
            cnt_reg  <= cnt_reg + 1'b1;
`endif
            case (state_reg)
                IDLE: begin
                    if (grant_en) begin
                        hs_data_reg   <= req_data_i[pick_idx*DataWidth +: DataWidth];
                        grant_idx_reg <= pick_idx;
                        ptr_reg       <= ptr_next;
                        hs_req_reg    <= 1'b1;
                        state_reg     <= REQ;
`ifdef SYNC_HS_TIMEOUT_EN
                        cnt_reg       <= '0;
                        err_flag_reg  <= 1'b0;
`endif
                    end
                end
                REQ: begin
                    if (ack_s) begin
                        hs_req_reg <= 1'b0;
                        state_reg  <= RELEASE;
`ifdef SYNC_HS_TIMEOUT_EN
                        cnt_reg    <= '0;
`endif
                    end
`ifdef SYNC_HS_TIMEOUT_EN
                    // Abandon the request; the error is reported when the phase closes.
                    else if (phase_timeout) begin
                        hs_req_reg   <= 1'b0;
                        state_reg    <= RELEASE;
                        cnt_reg      <= '0;
                        err_flag_reg <= 1'b1;
                    end
`endif
                end
                RELEASE: begin
                    if (!ack_s) begin
                        state_reg <= IDLE;
                        done_reg  <= NumReq'(1) << grant_idx_reg;
`ifdef SYNC_HS_TIMEOUT_EN
                        err_reg   <= err_flag_reg;
`endif
                    end
`ifdef SYNC_HS_TIMEOUT_EN
                    else if (phase_timeout) begin
                        state_reg <= IDLE;
                        done_reg  <= NumReq'(1) << grant_idx_reg;
                        err_reg   <= 1'b1;
                    end
`endif
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

    assign hs_req_o    = hs_req_reg;
    assign hs_data_o   = hs_data_reg;
    assign done_o      = done_reg;
    assign busy_o      = (state_reg != IDLE);
    assign grant_idx_o = grant_idx_reg;

endmodule

// File: tb/tb_sync_hs_arbiter.sv
// Scoreboard bench for sync_hs_arbiter: directed stimulus queues expected accepts and
// completions; a negedge monitor pops and compares whenever ready or done appears.
module tb_sync_hs_arbiter;

    localparam int NR = 4;
    localparam int DW = 32;

    logic            clk;
    logic            rst;
    logic [NR-1:0]   req_valid;
    logic [NR*DW-1:0] req_data;
    logic [NR-1:0]   req_ready;
    logic [NR-1:0]   done;
    logic            err;
    logic            hs_req;
    logic [DW-1:0]   hs_data;
    logic            hs_ack;
    logic            busy;
    logic [1:0]      grant_idx;

    logic            loop_en;
    logic            ack_force;

    int n_vec  = 0;
    int n_fail = 0;
    int cyc    = 0;

    typedef struct {
        logic [NR-1:0] mask;
        int            at;
    } acc_t;

    typedef struct {
        logic [NR-1:0] mask;
        logic          err;
        logic [DW-1:0] data;
        int            at;
    } done_t;

    acc_t  accq[$];
    done_t doneq[$];

    assign hs_ack = loop_en ? hs_req : ack_force;

    sync_hs_arbiter #(
        .NumReq        (NR),
        .DataWidth     (DW),
        .TimeoutCycles (16)
    ) dut (
        .clk_i       (clk),
        .rst_i       (rst),
        .req_valid_i (req_valid),
        .req_data_i  (req_data),
        .req_ready_o (req_ready),
        .done_o      (done),
        .err_o       (err),
        .hs_req_o    (hs_req),
        .hs_data_o   (hs_data),
        .hs_ack_i    (hs_ack),
        .busy_o      (busy),
        .grant_idx_o (grant_idx)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic exp_accept(input int k, input int at);
        acc_t a;
        a.mask = NR'(1) << k;
        a.at   = at;
        accq.push_back(a);
    endtask

    task automatic exp_done(input int k, input logic e, input logic [DW-1:0] d, input int at);
        done_t x;
        x.mask = NR'(1) << k;
        x.err  = e;
        x.data = d;
        x.at   = at;
        doneq.push_back(x);
    endtask

    // Monitor: every accept and every completion must match the head of its queue.
    initial begin
        acc_t  a;
        done_t x;
        forever begin
            @(negedge clk);
            if (req_ready !== '0) begin
                if (accq.size() == 0) begin
                    n_vec++;
                    n_fail++;
                    $display("FAIL unexpected_accept: got ready=%b, expected none (cycle %0d)", req_ready, cyc);
                end else begin
                    a = accq.pop_front();
                    $display("accept cycle=%0d ready=%b", cyc, req_ready);
                    chk("accept_mask", 64'(req_ready), 64'(a.mask));
                    chk("accept_cycle", 64'(cyc), 64'(a.at));
                end
            end
            if (done !== '0) begin
                if (doneq.size() == 0) begin
                    n_vec++;
                    n_fail++;
                    $display("FAIL unexpected_done: got done=%b, expected none (cycle %0d)", done, cyc);
                end else begin
                    x = doneq.pop_front();
                    $display("done   cycle=%0d done=%b err=%b data=%h", cyc, done, err, hs_data);
                    chk("done_mask", 64'(done), 64'(x.mask));
                    chk("done_err", 64'(err), 64'(x.err));
                    chk("done_data", 64'(hs_data), 64'(x.data));
                    chk("done_cycle", 64'(cyc), 64'(x.at));
                end
            end else if (err !== 1'b0) begin
                n_vec++;
                n_fail++;
                $display("FAIL err_without_done: got err=%b, expected 0 (cycle %0d)", err, cyc);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [DW-1:0] dat [NR];
        int b;
        dat[0] = 32'h0A0A0A0A;
        dat[1] = 32'h1B1B1B1B;
        dat[2] = 32'h2C2C2C2C;
        dat[3] = 32'h3D3D3D3D;

        rst       = 1'b1;
        req_valid = '0;
        req_data  = '0;
        loop_en   = 1'b0;
        ack_force = 1'b0;
        step(3);
        chk("rst_hs_req", 64'(hs_req), 64'd0);
        chk("rst_hs_data", 64'(hs_data), 64'd0);
        chk("rst_done", 64'(done), 64'd0);
        chk("rst_err", 64'(err), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_grant_idx", 64'(grant_idx), 64'd0);
        rst     = 1'b0;
        loop_en = 1'b1;
        step(2);

        // Loopback, single requester 2.
        b = cyc;
        req_valid[2] = 1'b1;
        req_data[2*DW +: DW] = 32'hDEADBEEF;
        exp_accept(2, b);
        exp_done(2, 1'b0, 32'hDEADBEEF, b + 7);
        step(1);
        req_valid = '0;
        chk("c1_hs_data", 64'(hs_data), 64'hDEADBEEF);
        chk("c1_hs_req", 64'(hs_req), 64'd1);
        chk("c1_grant_idx", 64'(grant_idx), 64'd2);
        chk("c1_busy", 64'(busy), 64'd1);
        step(9);

        // Reset to bring the pointer back to 0, then all four requesters continuously valid.
        rst = 1'b1;
        step(2);
        rst = 1'b0;
        step(2);
        for (int k = 0; k < NR; k++) req_data[k*DW +: DW] = dat[k];
        b = cyc;
        req_valid = '1;
        for (int j = 0; j < 5; j++) begin
            exp_accept(j % NR, b + 7*j);
            exp_done(j % NR, 1'b0, dat[j % NR], b + 7*j + 7);
        end
        step(29);
        req_valid = '0;
        step(8);

        // Stale ack held high through reset release blocks any grant.
        loop_en   = 1'b0;
        ack_force = 1'b1;
        rst       = 1'b1;
        step(2);
        rst = 1'b0;
        step(2);
        req_valid[0] = 1'b1;
        req_data[0 +: DW] = 32'hCAFEF00D;
        for (int i = 0; i < 4; i++) begin
            step(1);
            chk("stale_ack_block", 64'(req_ready), 64'd0);
        end
        b         = cyc;
        ack_force = 1'b0;
        loop_en   = 1'b1;
        exp_accept(0, b + 2);
        exp_done(0, 1'b0, 32'hCAFEF00D, b + 9);
        step(3);
        req_valid = '0;
        step(8);

        // Reset at C2 of a transaction: no completion, pointer back to 0.
        b = cyc;
        req_valid[1] = 1'b1;
        exp_accept(1, b);
        step(1);
        req_valid = '0;
        step(1);
        chk("pre_rst_hs_req", 64'(hs_req), 64'd1);
        rst = 1'b1;
        #1;
        chk("mid_rst_hs_req", 64'(hs_req), 64'd0);
        chk("mid_rst_busy", 64'(busy), 64'd0);
        chk("mid_rst_grant_idx", 64'(grant_idx), 64'd0);
        step(2);
        rst = 1'b0;
        step(4);
        b = cyc;
        req_valid[1] = 1'b1;
        req_valid[3] = 1'b1;
        exp_accept(1, b);
        exp_done(1, 1'b0, dat[1], b + 7);
        exp_accept(3, b + 7);
        exp_done(3, 1'b0, dat[3], b + 14);
        step(1);
        req_valid[1] = 1'b0;
        step(7);
        req_valid[3] = 1'b0;
        step(8);

`ifdef SYNC_HS_TIMEOUT_EN
        // Ack stuck low: request dropped after 16 REQ cycles, error completion.
        loop_en   = 1'b0;
        ack_force = 1'b0;
        b = cyc;
        req_valid[0] = 1'b1;
        exp_accept(0, b);
        exp_done(0, 1'b1, dat[0], b + 18);
        step(1);
        req_valid = '0;
        step(15);
        chk("to_req_still_high", 64'(hs_req), 64'd1);
        step(1);
        chk("to_req_dropped", 64'(hs_req), 64'd0);
        step(3);

        // Ack stuck high: RELEASE times out, then IDLE blocks grants.
        b = cyc;
        req_valid[1] = 1'b1;
        exp_accept(1, b);
        exp_done(1, 1'b1, dat[1], b + 20);
        step(1);
        req_valid = '0;
        ack_force = 1'b1;
        step(20);
        req_valid[2] = 1'b1;
        for (int i = 0; i < 5; i++) begin
            step(1);
            chk("to_idle_block", 64'(req_ready), 64'd0);
        end
        req_valid = '0;
        ack_force = 1'b0;
        step(4);
`endif

        chk("accq_empty", 64'(accq.size()), 64'd0);
        chk("doneq_empty", 64'(doneq.size()), 64'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule

// File: doc/sync_hs_arbiter.md
Name: sync_hs_arbiter

Overview:
- Shares one 4-phase req/ack handshake channel to a remote clock domain between NumReq local requesters.
- The remote ack arrives asynchronously and is resynchronised internally through a 2-flop synchronizer.
- A round-robin arbiter picks a requester. An FSM sequences req/ack and holds data stable on the channel.
- Sits on the local side of every slow CDC config/status path.

Parameters:
- NumReq, 4, number of requesters (>=2).
- DataWidth, 32, width of the payload carried alongside hs_req_o.
- TimeoutCycles, 1024, per-phase watchdog limit (used only with the optional feature).

Ports:
- clk_i  in  1  clock
- rst_i  in  1  asynchronous active-high reset
- req_valid_i  in  NumReq  per-requester request
- req_data_i  in  NumReq*DataWidth  payloads; requester k uses bits [k*DataWidth +: DataWidth]
- req_ready_o  out  NumReq  accept strobe (combinational, one-hot or zero)
- done_o  out  NumReq  one-cycle completion pulse to the granted requester
- err_o  out  1  one-cycle pulse with done_o when the transaction timed out
- hs_req_o  out  1  4-phase request level to the remote domain
- hs_data_o  out  DataWidth  payload, stable while hs_req_o=1 and until ack falls
- hs_ack_i  in  1  asynchronous remote acknowledge
- busy_o  out  1  FSM not in IDLE
- grant_idx_o  out  $clog2(NumReq)  index of the current/last granted requester

Behaviour:
- Reset is asynchronous and active-high: clk_i single clock, rst_i async active-high.
- On reset: hs_req_o=0, hs_data_o=0, done_o=0, err_o=0, busy_o=0, grant_idx_o=0, FSM=IDLE, round-robin pointer=0, sync flops=0.
- ack_s is hs_ack_i after the 2-flop synchronizer, giving 2 cycles of latency.
- IDLE:
  - If ack_s=0 and any req_valid_i is set, pick the first valid index at or after ptr, wrapping modulo NumReq.
  - Assert req_ready_o[idx] that cycle; the valid/ready transfer occurs then.
  - Register hs_data_o from that requester's payload, grant_idx_o<=idx, ptr<=idx+1 (wrapping at NumReq-1 -> 0), state->REQ.
  - If ack_s=1 (stale ack, e.g. after reset): no grant, req_ready_o=0.
- REQ: hs_req_o=1. When ack_s=1 -> RELEASE.
- RELEASE: hs_req_o=0, hs_data_o held. When ack_s=0 -> IDLE, and done_o[grant_idx_o]=1 for exactly the first IDLE cycle.
- New accepts are allowed in that same first IDLE cycle.
- Loopback timing (hs_ack_i wired to hs_req_o): accept at C0, hs_req_o high C1..C3, ack_s high C3..C5, done at C7. Back-to-back period is 7 cycles.
- req_valid_i dropping while not granted: no effect. Requesters must hold valid and data until ready.
- Reset mid-transaction: abandons the transaction with no done_o; hs_req_o=0 immediately. The IDLE guard waits for the remote ack to fall before any new grant.
- An ack_s glitch or change while in IDLE is ignored apart from the guard.

Optional Feature:
- Macro SYNC_HS_TIMEOUT_EN.
- Defined:
  - A phase counter clears on entry to REQ and RELEASE and increments each cycle in those states.
  - Count reaching TimeoutCycles-1 in REQ -> RELEASE (drop request).
  - Count reaching TimeoutCycles-1 in RELEASE -> IDLE, with done_o[grant_idx_o]=1 and err_o=1 for one cycle.
  - An abort from REQ that then completes normally in RELEASE also sets err_o with done_o (sticky err flag per transaction).
- Undefined: no counter, FSM waits indefinitely, err_o tied 0.

Decomposition:
- Package sync_hs_pkg: state enum {IDLE, REQ, RELEASE}, 2-bit encoding; default timeout constant.
- Sub-module: the codebase's existing 2-flop synchronizer prim_flop_2sync, Width=1, ResetValue=0, rst_ni driven by ~rst_i, synchronising hs_ack_i.
- Arbiter priority logic stays inline.

Test Plan:
- Loopback, single requester 2 with data 0xDEADBEEF -> req_ready_o=4'b0100 at C0, hs_data_o=0xDEADBEEF at C1, done_o=4'b0100 at C7, err_o=0.
- All 4 valid continuously, loopback -> grants in order 0,1,2,3,0, each 7 cycles apart, with no starvation.
- hs_ack_i held 1 through reset release, requester 0 valid -> no req_ready_o until hs_ack_i drops, then grant 2 cycles later.
- Reset asserted at C2 of a transaction -> hs_req_o=0 asynchronously, no done_o, ptr=0 after release.
- SYNC_HS_TIMEOUT_EN, TimeoutCycles=16, hs_ack_i stuck 0 -> hs_req_o falls after 16 cycles in REQ; done_o and err_o pulse once ack_s=0 is seen.
- SYNC_HS_TIMEOUT_EN, hs_ack_i stuck 1 after request -> RELEASE times out after 16 cycles; done_o and err_o pulse; IDLE then blocks grants.
